// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: issues four byte reads per word, assembles them
// little-endian and pushes {instr, pc} into a small output FIFO.
module ifetch_seq #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       fetch_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]     rsv_q, rsv_d;
  logic              rd_vld_q;
  logic [1:0]        rd_lane_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [2:0][7:0]   lane_q;
  ent_t              fifo_q [DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;
  logic [15:0]       fcnt_q;

  logic              start, started, push, pop;
  logic [ADDR_W-1:0] tgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // rsv_q counts FIFO entries plus words in flight, so a push never hits a full FIFO
  assign start = en && (rsv_q < CW'(DEPTH));
  assign tgt   = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign push  = rd_vld_q && (rd_lane_q == 2'd3) && !redirect_valid;
  assign pop   = out_valid && out_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pc_d       = pc_q;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    started    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d    = ISSUE;
        k_d        = 2'd0;
        mem_re_d   = 1'b1;
        mem_addr_d = pc_q;
        started    = 1'b1;
      end
      ISSUE: if (k_q != 2'd3) begin
        k_d        = k_q + 2'd1;
        mem_re_d   = 1'b1;
        mem_addr_d = pc_q + ADDR_W'(k_q) + ADDR_W'(1);
      end else begin
        pc_d = pc_q + ADDR_W'(4);
        k_d  = 2'd0;
        if (start) begin
          mem_re_d   = 1'b1;
          mem_addr_d = pc_q + ADDR_W'(4);
          started    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d       = tgt;
      k_d        = 2'd0;
      started    = en;
      mem_re_d   = en;
      mem_addr_d = en ? tgt : mem_addr_q;
      state_d    = en ? ISSUE : IDLE;
    end
  end

  always_comb begin
    rsv_d = rsv_q;
    if (redirect_valid) rsv_d = en ? CW'(1) : '0;
    else                rsv_d = rsv_q + CW'(started) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      pc_q       <= RESET_PC;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      rsv_q      <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pc_q       <= pc_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      rsv_q      <= rsv_d;
    end
  end

  // Read-return tracking: the byte on mem_rdata belongs to last cycle's read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      rd_lane_q <= '0;
      rd_addr_q <= '0;
      lane_q    <= '0;
    end else begin
      rd_vld_q  <= mem_re_q && !redirect_valid;
      rd_lane_q <= k_q;
      rd_addr_q <= mem_addr_q;
      if (rd_vld_q && rd_lane_q != 2'd3) lane_q[rd_lane_q] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
    end else if (redirect_valid) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wp_q] <= '{instr: {mem_rdata, lane_q[2], lane_q[1], lane_q[0]},
                          pc:    rd_addr_q - ADDR_W'(3)};
        wp_q   <= ptr_inc(wp_q);
        fcnt_q <= fcnt_q + 16'd1;
      end
      if (pop) rp_q <= ptr_inc(rp_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign mem_re      = mem_re_q;
  assign mem_addr    = mem_addr_q;
  assign out_valid   = (cnt_q != '0);
  assign out_instr   = fifo_q[rp_q].instr;
  assign out_pc      = fifo_q[rp_q].pc;
  assign fetch_count = fcnt_q;
endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: byte memory model plus hand-computed expectations.
module tb_ifetch_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [15:0] fetch_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [256];

  ifetch_seq #(.ADDR_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rst_pulse();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;

    // reset state
    tick(); tick();
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_fetch_count", 32'(fetch_count), 0);

    // first word latency
    @(negedge clk);
    reset = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_mem_re", 32'(mem_re), 1);
      chk("t1_mem_addr", 32'(mem_addr), 32'(i));
    end
    tick();
    chk("t1_valid_c5", 32'(out_valid), 0);
    tick();
    chk("t1_valid_c6", 32'(out_valid), 1);
    chk("t1_instr", out_instr, 32'h00A00513);
    chk("t1_pc", 32'(out_pc), 0);
    chk("t1_count", 32'(fetch_count), 1);

    // backpressure fills exactly DEPTH words, then redirect mid-word
    out_ready = 1'b0;
    rst_pulse();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_mem_addr", 32'(mem_addr), 32'(i));
    end
    tick();
    chk("t2_stop_c9", 32'(mem_re), 0);
    tick();
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_pc0", 32'(out_pc), 0);
    chk("t2_instr0", out_instr, 32'h00A00513);
    chk("t2_count", 32'(fetch_count), 2);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_stall_re", 32'(mem_re), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("t2_valid1", 32'(out_valid), 1);
    chk("t2_pc1", 32'(out_pc), 32'h04);
    chk("t2_instr1", out_instr, 32'h07060504);
    tick();
    chk("t2_resume_re", 32'(mem_re), 1);
    chk("t2_resume_addr", 32'(mem_addr), 32'h08);
    chk("t2_empty", 32'(out_valid), 0);
    tick();
    tick();
    chk("t3_k2_addr", 32'(mem_addr), 32'h0A);
    redirect_valid = 1'b1; redirect_pc = 8'h22;
    tick();
    redirect_valid = 1'b0;
    chk("t3_redir_re", 32'(mem_re), 1);
    chk("t3_redir_addr", 32'(mem_addr), 32'h20);
    chk("t3_flushed", 32'(out_valid), 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t3_addr", 32'(mem_addr), 32'h20 + 32'(i));
    end
    tick();
    chk("t3_valid_early", 32'(out_valid), 0);
    tick();
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_pc", 32'(out_pc), 32'h20);
    chk("t3_instr", out_instr, 32'h23222120);
    chk("t3_count", 32'(fetch_count), 3);

    // redirect on the lane-3 capture edge with a pop pending, target wraps at FC
    out_ready = 1'b0;
    rst_pulse();
    for (int i = 0; i < 9; i++) tick();
    chk("t4_pre_valid", 32'(out_valid), 1);
    chk("t4_pre_count", 32'(fetch_count), 1);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    chk("t4_no_pop_valid", 32'(out_valid), 0);
    chk("t4_no_push_count", 32'(fetch_count), 1);
    chk("t4_addr_fc", 32'(mem_addr), 32'hFC);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t5_addr", 32'(mem_addr), 32'hFC + 32'(i));
    end
    tick();
    chk("t5_wrap_addr", 32'(mem_addr), 32'h00);
    tick();
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_pc", 32'(out_pc), 32'hFC);
    chk("t5_instr", out_instr, 32'hFFFEFDFC);
    chk("t5_count", 32'(fetch_count), 2);
    out_ready = 1'b0;
    tick();
    chk("t6_mid_addr", 32'(mem_addr), 32'h02);
    chk("t6_mid_valid", 32'(out_valid), 1);

    // asynchronous reset between edges, then en dropped mid-word
    #3 reset = 1'b1;
    #1;
    chk("t6_async_re", 32'(mem_re), 0);
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_count", 32'(fetch_count), 0);
    out_ready = 1'b1; en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t6_restart_addr", 32'(mem_addr), 32'h00);
    en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t7_finish_re", 32'(mem_re), 1);
      chk("t7_finish_addr", 32'(mem_addr), 32'(i));
    end
    tick();
    chk("t7_no_new_word", 32'(mem_re), 0);
    tick();
    chk("t7_valid", 32'(out_valid), 1);
    chk("t7_instr", out_instr, 32'h00A00513);
    chk("t7_count", 32'(fetch_count), 1);
    tick();
    chk("t7_popped", 32'(out_valid), 0);
    chk("t7_idle", 32'(mem_re), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Fetch sequencer in the Instruction Fetch stage. It owns the PC and drives the byte-wide, 256-entry, little-endian instruction memory one byte per cycle.
- Each instruction is assembled from four consecutive bytes and pushed into a small output FIFO toward the IF/ID register.
- The FIFO hands instructions downstream with a valid/ready handshake.
- Branch/jump redirects flush in-flight work and restart fetch at the new target.

Parameters:
- ADDR_W, 8, byte address width; PC and memory addresses wrap modulo 2^ADDR_W.
- DEPTH, 2, output FIFO entries (power of two, at least 1).
- RESET_PC, 8'h00, PC loaded on reset; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  fetch enable; gates the start of new words only.
- mem_re  output  1  byte read strobe.
- mem_addr  output  ADDR_W  byte address, valid while mem_re=1.
- mem_rdata  input  8  byte data, valid the cycle after the matching mem_re.
- out_valid  output  1  FIFO head holds an instruction.
- out_ready  input  1  downstream accepts the head.
- out_instr  output  32  head instruction {b3,b2,b1,b0}.
- out_pc  output  ADDR_W  byte address of b0 of the head instruction.
- redirect_valid  input  1  load a new PC this cycle.
- redirect_pc  input  ADDR_W  redirect target.
- fetch_count  output  16  count of instructions pushed into the FIFO; wraps at 2^16.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=RESET_PC; FIFO empty.
  - out_valid=0, out_instr=0, out_pc=0.
  - mem_re=0, mem_addr=0, fetch_count=0.
  - byte index=0, no read in flight.
- mem_re and mem_addr are registered outputs.
- States:
  - IDLE: no word in progress. Go to ISSUE when en=1 and (FIFO count + words in assembly) < DEPTH.
  - ISSUE: four cycles, k=0..3, each with mem_re=1 and mem_addr=(pc+k) mod 2^ADDR_W.
    - After k=3: pc <= pc+4 (mod 2^ADDR_W).
    - If the start condition still holds, start the next word back-to-back (k=0 in the very next cycle). Otherwise go to IDLE.
- Capture:
  - The byte read in cycle t is taken from mem_rdata at the end of cycle t+1 into byte lane k.
  - When lane 3 is captured, {b3,b2,b1,b0} and the word's start PC are pushed into the FIFO at that edge, and fetch_count increments.
- Latency:
  - First mem_re at cycle t gives out_valid=1 in cycle t+5 when the FIFO was empty.
  - Sustained throughput is 1 instruction per 4 cycles.
- Space reservation:
  - A word is started only if a FIFO slot is reserved for it.
  - A push therefore never meets a full FIFO, and the assembly path never stalls mid-word.
- Handshake:
  - Pop happens on out_valid & out_ready.
  - out_instr and out_pc are stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle leave the count unchanged.
  - out_valid is driven from FIFO state only, with no combinational path from out_ready.
- Redirect (redirect_valid=1 at an edge):
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}; low two bits are ignored.
  - FIFO is cleared (out_valid=0 next cycle) and the partial word is discarded.
  - A byte returning in the next cycle from a pre-redirect read is dropped.
  - No push occurs on the redirect edge, even if lane 3 completes on it, and fetch_count does not increment for that word.
  - Redirect has priority over push, pop and issue in the same cycle.
  - Issue of the new target starts the following cycle, provided en=1.
  - mem_re is 0 in the redirect cycle's successor only if en=0.
- en=0:
  - A word in ISSUE finishes its remaining bytes and is pushed normally.
  - No new word starts. FIFO contents remain poppable.
- Wrap: a word at pc=8'hFC reads FC..FF; the next pc is 8'h00.
- Reset asserted mid-word: state clears immediately and the partial word is lost.

Test Plan:
- Reset, then en=1 with mem bytes 00:13 05 A0 00 (addi x10,x0,10), out_ready=1 -> mem_addr 00,01,02,03 in cycles 1-4; out_valid in cycle 6 with out_instr=32'h00A00513, out_pc=00, fetch_count=1.
- out_ready=0 with continuous fetch, DEPTH=2 -> exactly two words (pc 00, 04) buffered; no mem_re after byte 07. Raise out_ready -> pops in order 00 then 04, then fetch resumes at 08.
- redirect_valid with redirect_pc=8'h22 while byte k=2 of the word at 08 is being issued -> partial word dropped, FIFO empty. Next mem_addr sequence is 20,21,22,23; out_pc=20; fetch_count excludes the dropped word.
- redirect_valid on the same edge as lane-3 capture and out_ready=1 -> no push and no pop; FIFO empty; fetch restarts at the target.
- pc set to 8'hFC by redirect -> reads FC..FF, out_pc=FC, next issue at 00.
- Reset asserted asynchronously mid-word (between clock edges) -> mem_re=0 and out_valid=0 immediately. After release, fetch restarts at RESET_PC.
